// File: rtl/br_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating counters,
// selectable bimodal or gshare indexing, and resolution statistics.
module br_predictor_btb #(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned TAG_BITS  = 8,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned MODE      = 0,
    parameter int unsigned STAT_BITS = 32,
    localparam int unsigned IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          pc_i,
    output logic                 pred_taken_o,
    output logic [31:0]          pred_target_o,
    output logic [IDX_BITS-1:0]  pred_ghr_o,
    input  logic                 upd_valid_i,
    input  logic [31:0]          upd_pc_i,
    input  logic [IDX_BITS-1:0]  upd_ghr_i,
    input  logic                 upd_taken_i,
    input  logic [31:0]          upd_target_i,
    input  logic                 upd_mispred_i,
    input  logic                 flush_i,
    output logic [STAT_BITS-1:0] stat_branches_o,
    output logic [STAT_BITS-1:0] stat_miss_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK_T = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WEAK_N = CNT_WEAK_T - CNT_BITS'(1);

    // Table storage, kept in flops so lookup is purely combinational.
    logic                 valid_q [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q   [ENTRIES];
    logic [31:0]          tgt_q   [ENTRIES];
    logic [CNT_BITS-1:0]  cnt_q   [ENTRIES];
    logic [IDX_BITS-1:0]  ghr_q;
    logic [STAT_BITS-1:0] br_cnt_q;
    logic [STAT_BITS-1:0] miss_cnt_q;

    logic [IDX_BITS-1:0]  lk_idx;
    logic                 lk_hit;
    logic [IDX_BITS-1:0]  up_idx;
    logic                 up_hit;
    logic [CNT_BITS-1:0]  cnt_nxt;
    logic                 unused_pc_bits;

    // Entry index from the PC index field, folded with history in gshare mode.
    function automatic logic [IDX_BITS-1:0] idx_of(input logic [IDX_BITS-1:0] field,
                                                   input logic [IDX_BITS-1:0] hist);
        return (MODE == 1) ? (field ^ hist) : field;
    endfunction

    // Low PC bits and bits above the tag never take part in indexing or tagging.
    assign unused_pc_bits = ^{pc_i, upd_pc_i};

    // Fetch-side lookup against pre-update table contents.
    assign lk_idx        = idx_of(pc_i[IDX_BITS+1:2], ghr_q);
    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == pc_i[IDX_BITS+2 +: TAG_BITS]);
    assign pred_taken_o  = lk_hit && cnt_q[lk_idx][CNT_BITS-1];
    assign pred_target_o = pred_taken_o ? tgt_q[lk_idx] : 32'h0;
    assign pred_ghr_o    = (MODE == 1) ? ghr_q : '0;

    // Resolution-side entry selection and hit detection.
    assign up_idx = idx_of(upd_pc_i[IDX_BITS+1:2], upd_ghr_i);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == upd_pc_i[IDX_BITS+2 +: TAG_BITS]);

    // Saturating counter step toward the resolved outcome.
    always_comb begin
        cnt_nxt = cnt_q[up_idx];
        if (upd_taken_i) begin
            if (cnt_q[up_idx] != CNT_MAX) cnt_nxt = cnt_q[up_idx] + CNT_BITS'(1);
        end else begin
            if (cnt_q[up_idx] != '0) cnt_nxt = cnt_q[up_idx] - CNT_BITS'(1);
        end
    end

    // Table and history training; flush overrides any same-cycle update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= 32'h0;
                cnt_q[i]   <= CNT_WEAK_N;
            end
            ghr_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
            end
            ghr_q <= '0;
        end else if (upd_valid_i) begin
            if (up_hit) begin
                cnt_q[up_idx] <= cnt_nxt;
                if (upd_taken_i) tgt_q[up_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= upd_pc_i[IDX_BITS+2 +: TAG_BITS];
                tgt_q[up_idx]   <= upd_target_i;
                cnt_q[up_idx]   <= CNT_WEAK_T;
            end
            if (MODE == 1) ghr_q <= IDX_BITS'({ghr_q, upd_taken_i});
        end
    end

    // Saturating resolution and misprediction counters; immune to flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (upd_valid_i) begin
            if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + STAT_BITS'(1);
            if (upd_mispred_i && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + STAT_BITS'(1);
        end
    end

    assign stat_branches_o = br_cnt_q;
    assign stat_miss_o     = miss_cnt_q;

endmodule

// File: tb/tb_br_predictor_btb.sv
// Bench for br_predictor_btb: a bimodal instance with narrow statistics and a
// gshare instance share stimulus; an abstract table model predicts both.
module tb_br_predictor_btb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr_b;
    logic [3:0]  upd_ghr_g;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic        flush;
    logic        chk_en = 1'b0;

    logic        pt_b, pt_g;
    logic [31:0] tg_b, tg_g;
    logic [3:0]  gh_b, gh_g;
    logic [3:0]  br_b, ms_b;
    logic [31:0] br_g, ms_g;

    int n_chk  = 0;
    int n_pass = 0;

    // Abstract model: index 0 = bimodal/4-bit stats, index 1 = gshare/32-bit stats.
    bit          mv    [2][16];
    int          mtag  [2][16];
    int          mcnt  [2][16];
    logic [31:0] mtgt  [2][16];
    int          mghr  [2];
    longint      mbr   [2];
    longint      mmiss [2];

    always #5 clk = ~clk;

    br_predictor_btb #(.ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(0), .STAT_BITS(4)) dut_b (
        .clk(clk), .reset_n(rst_n), .pc_i(pc_i),
        .pred_taken_o(pt_b), .pred_target_o(tg_b), .pred_ghr_o(gh_b),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr_b),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
        .flush_i(flush), .stat_branches_o(br_b), .stat_miss_o(ms_b)
    );

    br_predictor_btb #(.ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(1), .STAT_BITS(32)) dut_g (
        .clk(clk), .reset_n(rst_n), .pc_i(pc_i),
        .pred_taken_o(pt_g), .pred_target_o(tg_g), .pred_ghr_o(gh_g),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr_g),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
        .flush_i(flush), .stat_branches_o(br_g), .stat_miss_o(ms_g)
    );

    function automatic int midx(input int m, input logic [31:0] pc, input int g);
        int f;
        f = int'((pc >> 2) & 32'hF);
        return (m == 1) ? ((f ^ g) % 16) : f;
    endfunction

    function automatic int mtagf(input logic [31:0] pc);
        return int'((pc >> 6) & 32'hFF);
    endfunction

    function automatic longint smax(input int m);
        return (m == 0) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    function automatic bit exp_taken(input int m, input logic [31:0] pc);
        int i;
        i = midx(m, pc, mghr[m]);
        return mv[m][i] && (mtag[m][i] == mtagf(pc)) && (mcnt[m][i] >= 2);
    endfunction

    function automatic logic [31:0] exp_tgt(input int m, input logic [31:0] pc);
        return exp_taken(m, pc) ? mtgt[m][midx(m, pc, mghr[m])] : 32'h0;
    endfunction

    // Model state advance on each clock, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 16; i++) begin
                    mv[m][i]   <= 1'b0;
                    mtag[m][i] <= 0;
                    mcnt[m][i] <= 1;
                    mtgt[m][i] <= 32'h0;
                end
                mghr[m]  <= 0;
                mbr[m]   <= 0;
                mmiss[m] <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int ui;
                bit uh;
                if (upd_valid) begin
                    mbr[m] <= (mbr[m] < smax(m)) ? mbr[m] + 1 : mbr[m];
                    if (upd_mispred) mmiss[m] <= (mmiss[m] < smax(m)) ? mmiss[m] + 1 : mmiss[m];
                end
                if (flush) begin
                    for (int i = 0; i < 16; i++) mv[m][i] <= 1'b0;
                    mghr[m] <= 0;
                end else if (upd_valid) begin
                    ui = midx(m, upd_pc, (m == 1) ? int'(upd_ghr_g) : int'(upd_ghr_b));
                    uh = mv[m][ui] && (mtag[m][ui] == mtagf(upd_pc));
                    if (uh) begin
                        if (upd_taken) begin
                            mcnt[m][ui] <= (mcnt[m][ui] < 3) ? mcnt[m][ui] + 1 : 3;
                            mtgt[m][ui] <= upd_target;
                        end else begin
                            mcnt[m][ui] <= (mcnt[m][ui] > 0) ? mcnt[m][ui] - 1 : 0;
                        end
                    end else if (upd_taken) begin
                        mv[m][ui]   <= 1'b1;
                        mtag[m][ui] <= mtagf(upd_pc);
                        mtgt[m][ui] <= upd_target;
                        mcnt[m][ui] <= 2;
                    end
                    if (m == 1) mghr[m] <= ((mghr[m] * 2) + (upd_taken ? 1 : 0)) % 16;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp(input int m, input logic t, input logic [31:0] tg, input logic [3:0] gh,
                       input logic [63:0] br, input logic [63:0] ms);
        string s;
        s = (m == 0) ? "b" : "g";
        chk({"cyc_taken_", s},  64'(t),  64'(exp_taken(m, pc_i)));
        chk({"cyc_target_", s}, 64'(tg), 64'(exp_tgt(m, pc_i)));
        chk({"cyc_ghr_", s},    64'(gh), (m == 1) ? 64'(mghr[1]) : 64'd0);
        chk({"cyc_stat_br_", s},   br, 64'(mbr[m]));
        chk({"cyc_stat_miss_", s}, ms, 64'(mmiss[m]));
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, pt_b, tg_b, gh_b, 64'(br_b), 64'(ms_b));
            cmp(1, pt_g, tg_g, gh_g, 64'(br_g), 64'(ms_g));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_mispred = mp;
        upd_ghr_g   = 4'(mghr[1]);
        tick();
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        pc_i = pc;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; pc_i = 32'h100; upd_valid = 1'b0; upd_pc = 32'h0;
        upd_ghr_b = 4'h0; upd_ghr_g = 4'h0; upd_taken = 1'b0; upd_target = 32'h0;
        upd_mispred = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        look(32'h100);
        chk("rst_taken_b", 64'(pt_b), 64'd0);
        chk("rst_target_b", 64'(tg_b), 64'd0);
        chk("rst_ghr_g", 64'(gh_g), 64'd0);
        chk("rst_stat_br_g", 64'(br_g), 64'd0);
        chk("rst_stat_miss_g", 64'(ms_g), 64'd0);

        // First taken allocation -> weakly taken with its target.
        do_upd(32'h100, 1'b1, 32'h200, 1'b1);
        look(32'h100);
        chk("alloc_taken_b", 64'(pt_b), 64'd1);
        chk("alloc_target_b", 64'(tg_b), 64'h200);
        chk("alloc_ghr_g", 64'(gh_g), 64'd1);
        chk("alloc_stat_br_b", 64'(br_b), 64'd1);

        // Two not-taken -> counter 0.
        do_upd(32'h100, 1'b0, 32'h0, 1'b1);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        chk("nt2_taken_b", 64'(pt_b), 64'd0);

        // Five taken saturate at 3; one not-taken still predicts taken, second does not.
        repeat (5) do_upd(32'h100, 1'b1, 32'h200, 1'b0);
        look(32'h100);
        chk("t5_taken_b", 64'(pt_b), 64'd1);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        chk("sat_n1_taken_b", 64'(pt_b), 64'd1);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        chk("sat_n2_taken_b", 64'(pt_b), 64'd0);

        // Aliasing: same index, different tag, overwrites entry.
        do_upd(32'h100, 1'b1, 32'h300, 1'b0);
        look(32'h100);
        chk("retgt_target_b", 64'(tg_b), 64'h300);
        do_upd(32'h140, 1'b1, 32'h440, 1'b1);
        look(32'h100);
        chk("alias_old_taken_b", 64'(pt_b), 64'd0);
        look(32'h140);
        chk("alias_new_target_b", 64'(tg_b), 64'h440);

        // Same-cycle lookup and update see old contents first.
        pc_i = 32'h184; upd_valid = 1'b1; upd_pc = 32'h184; upd_taken = 1'b1;
        upd_target = 32'h500; upd_mispred = 1'b0; upd_ghr_g = 4'(mghr[1]);
        #1;
        chk("same_cyc_old_taken_b", 64'(pt_b), 64'd0);
        tick();
        upd_valid = 1'b0; upd_taken = 1'b0;
        look(32'h184);
        chk("same_cyc_new_taken_b", 64'(pt_b), 64'd1);
        chk("same_cyc_new_target_b", 64'(tg_b), 64'h500);

        // Flush beats a same-cycle update but statistics still count it.
        flush = 1'b1;
        do_upd(32'h3c0, 1'b1, 32'h900, 1'b1);
        flush = 1'b0;
        look(32'h100);
        chk("flush_taken_b_100", 64'(pt_b), 64'd0);
        look(32'h140);
        chk("flush_taken_b_140", 64'(pt_b), 64'd0);
        look(32'h184);
        chk("flush_taken_b_184", 64'(pt_b), 64'd0);
        chk("flush_ghr_g", 64'(gh_g), 64'd0);
        chk("flush_stat_br_b", 64'(br_b), 64'd14);
        chk("flush_stat_br_g", 64'(br_g), 64'd14);
        chk("flush_stat_miss_g", 64'(ms_g), 64'd4);

        // Gshare history T,N,T then train through the history-folded index.
        do_upd(32'h200, 1'b1, 32'h600, 1'b0);
        do_upd(32'h204, 1'b0, 32'h0, 1'b0);
        do_upd(32'h208, 1'b1, 32'h700, 1'b0);
        look(32'h100);
        chk("tnt_ghr_g", 64'(gh_g), 64'h5);
        chk("sat_stat_br_b", 64'(br_b), 64'd15);
        chk("tnt_stat_br_g", 64'(br_g), 64'd17);
        do_upd(32'h100, 1'b1, 32'h800, 1'b1);
        look(32'h138);
        chk("gshare_taken_g", 64'(pt_g), 64'd1);
        chk("gshare_target_g", 64'(tg_g), 64'h800);

        // Push past 20 updates; 4-bit branch count holds at 15.
        repeat (4) do_upd(32'h3c0, 1'b0, 32'h0, 1'b1);
        look(32'h3c0);
        chk("hold_stat_br_b", 64'(br_b), 64'd15);
        chk("end_stat_br_g", 64'(br_g), 64'd22);
        chk("end_stat_miss_b", 64'(ms_b), 64'd9);

        // Async reset mid-operation discards a pending update.
        pc_i = 32'h138; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
        upd_target = 32'h200; upd_mispred = 1'b1; upd_ghr_g = 4'(mghr[1]);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_taken_g", 64'(pt_g), 64'd0);
        chk("midrst_ghr_g", 64'(gh_g), 64'd0);
        chk("midrst_stat_br_g", 64'(br_g), 64'd0);
        chk("midrst_stat_miss_b", 64'(ms_b), 64'd0);
        tick();
        upd_valid = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
        rst_n = 1'b1;
        look(32'h100);
        chk("postrst_taken_b", 64'(pt_b), 64'd0);
        chk("postrst_stat_br_b", 64'(br_b), 64'd0);
        look(32'h138);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
